// File: rtl/mips_pipe_skid_stage_pkg.sv
// mips_pipe_skid_stage_pkg: shared widths, word/flag indices and entry-width helper for the skid stage
package mips_pipe_skid_stage_pkg;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 5;
    localparam int EXC_W     = 5;
    localparam int FLAG_W    = 9;
    localparam int W_IR      = 0;
    localparam int W_PC8     = 1;
    localparam int W_ALUOUT  = 2;
    localparam int W_RT      = 3;
    localparam int W_XALUOUT = 4;
    localparam int F_CAL_R   = 0;
    localparam int F_CAL_I   = 1;
    localparam int F_LOAD    = 2;
    localparam int F_STORE   = 3;
    localparam int F_BRANCH  = 4;
    localparam int F_JUMP    = 5;
    localparam int F_MTC0    = 6;
    localparam int F_ERET    = 7;
    localparam int F_MFC0    = 8;
    function automatic int entry_w(input int nw, input int ew, input int fw);
        return nw * WORD_W + ew + fw + 1;
    endfunction
endpackage

// File: rtl/mips_pipe_entry.sv
// mips_pipe_entry: one valid-tagged storage slot; clear wins over load and zeroes the payload
module mips_pipe_entry #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_data,
    output logic         vld,
    output logic [W-1:0] data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    always_comb begin
        valid_d = clr ? 1'b0 : (ld ? 1'b1 : valid_q);
        data_d  = clr ? '0 : (ld ? ld_data : data_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign vld  = valid_q;
    assign data = data_q;
endmodule

// File: rtl/mips_pipe_skid_stage.sv
// mips_pipe_skid_stage: flushable valid/ready stage register with a 2-entry skid buffer (main + skid)
module mips_pipe_skid_stage
    import mips_pipe_skid_stage_pkg::*;
#(
    parameter int NUM_WORDS = mips_pipe_skid_stage_pkg::NUM_WORDS,
    parameter int EXC_W     = mips_pipe_skid_stage_pkg::EXC_W,
    parameter int FLAG_W    = mips_pipe_skid_stage_pkg::FLAG_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_WORDS*32-1:0] in_words,
    input  logic [EXC_W-1:0]        in_exc,
    input  logic [FLAG_W-1:0]       in_flags,
    input  logic                    in_dslot,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_WORDS*32-1:0] out_words,
    output logic [EXC_W-1:0]        out_exc,
    output logic [FLAG_W-1:0]       out_flags,
    output logic                    out_dslot,
    output logic [1:0]              occupancy
);
    localparam int W = entry_w(NUM_WORDS, EXC_W, FLAG_W);
    logic         main_v, skid_v, acc, pop;
    logic         main_ld, main_clr, skid_ld, skid_clr;
    logic [W-1:0] main_data, skid_data, in_data, main_ld_data;
    assign in_data = {in_words, in_exc, in_flags, in_dslot};
    // Main refills from skid first to keep FIFO order; flush overrides every load.
    always_comb begin
        acc          = in_valid & in_ready;
        pop          = main_v & out_ready;
        main_ld      = ~flush & ((pop & skid_v) | (acc & (~main_v | pop)));
        main_clr     = flush | (pop & ~skid_v & ~acc);
        main_ld_data = skid_v ? skid_data : in_data;
        skid_ld      = ~flush & acc & main_v & ~pop;
        skid_clr     = flush | (pop & skid_v);
    end
    mips_pipe_entry #(.W(W)) u_main (
        .clk(clk), .reset(reset), .clr(main_clr), .ld(main_ld),
        .ld_data(main_ld_data), .vld(main_v), .data(main_data)
    );
    mips_pipe_entry #(.W(W)) u_skid (
        .clk(clk), .reset(reset), .clr(skid_clr), .ld(skid_ld),
        .ld_data(in_data), .vld(skid_v), .data(skid_data)
    );
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign {out_words, out_exc, out_flags, out_dslot} = main_data;
    assign occupancy = 2'(main_v) + 2'(skid_v);
endmodule

// File: tb/tb_mips_pipe_skid_stage.sv
// tb_mips_pipe_skid_stage: table-driven handshake vectors with a beat scoreboard queue for mips_pipe_skid_stage
module tb_mips_pipe_skid_stage;
    localparam int NW = 5;
    localparam int EW = 5;
    localparam int FW = 9;
    typedef struct packed {
        logic [NW*32-1:0] words;
        logic [EW-1:0]    exc;
        logic [FW-1:0]    flags;
        logic             dslot;
    } beat_t;
    typedef struct {
        logic iv, ordy, fl, rs;
        int   occ;
        logic rdy;
    } vec_t;

    logic clk = 1'b0, reset, flush, in_valid, in_ready, in_dslot, out_valid, out_ready, out_dslot;
    logic [NW*32-1:0] in_words, out_words;
    logic [EW-1:0] in_exc, out_exc;
    logic [FW-1:0] in_flags, out_flags;
    logic [1:0] occupancy;
    beat_t mq[$];
    vec_t vecs[$];
    int checks = 0, errors = 0, seq = 0;
    bit started = 0;

    always #5 clk = ~clk;

    mips_pipe_skid_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_words(in_words), .in_exc(in_exc), .in_flags(in_flags), .in_dslot(in_dslot),
        .out_valid(out_valid), .out_ready(out_ready), .out_words(out_words), .out_exc(out_exc),
        .out_flags(out_flags), .out_dslot(out_dslot), .occupancy(occupancy)
    );

    function automatic beat_t make_beat(input int s);
        beat_t b;
        for (int k = 0; k < NW; k++) b.words[32*k +: 32] = {8'(k), 8'hC0, 16'(s)};
        if (s == 0) b.words[31:0] = 32'h8C430004;
        b.exc   = 5'(s);
        b.flags = 9'(s * 37);
        b.dslot = s[0];
        if (s == 4) begin
            b.exc   = 5'd4;
            b.flags = 9'h004;
            b.dslot = 1'b1;
        end
        return b;
    endfunction

    function automatic vec_t v(input logic iv, ordy, fl, rs, input int occ, input logic rdy);
        vec_t r;
        r.iv = iv; r.ordy = ordy; r.fl = fl; r.rs = rs; r.occ = occ; r.rdy = rdy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic beat_t out_beat();
        return {out_words, out_exc, out_flags, out_dslot};
    endfunction

    // One clock: compare the visible stage against the queue, then advance both.
    task automatic cycle(input logic iv, ordy, fl, rs);
        beat_t cur, front;
        logic m_acc, m_pop;
        cur = make_beat(seq);
        in_valid = iv; out_ready = ordy; flush = fl; reset = rs;
        {in_words, in_exc, in_flags, in_dslot} = cur;
        #1;
        if (started) begin
            front = (mq.size() > 0) ? mq[0] : '0;
            chk("in_ready", 192'(in_ready), 192'(mq.size() < 2));
            chk("out_valid", 192'(out_valid), 192'(mq.size() > 0));
            chk("out_beat", 192'(out_beat()), 192'(front));
        end
        m_acc = iv && mq.size() < 2;
        m_pop = ordy && mq.size() > 0;
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
            if (iv) seq++;
        end else begin
            if (m_pop) front = mq.pop_front();
            if (m_acc) begin
                mq.push_back(cur);
                seq++;
            end
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (started && out_valid !== 1'b1) begin
            checks++;
            assert (out_beat() === '0) else begin
                errors++;
                $display("FAIL idle_zero actual=%0h required=0", out_beat());
            end
        end
    end

    initial begin
        beat_t held;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        {in_words, in_exc, in_flags, in_dslot} = '0;
        @(negedge clk);
        vecs.push_back(v(0, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 1, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 1));
        for (int i = 0; i < 8; i++) vecs.push_back(v(1, 1, 0, 0, 1, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 1));
        vecs.push_back(v(1, 0, 0, 0, 2, 0));
        vecs.push_back(v(1, 0, 0, 0, 2, 0));
        vecs.push_back(v(1, 1, 0, 0, 1, 1));
        vecs.push_back(v(1, 1, 0, 0, 1, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 1, 1));
        vecs.push_back(v(1, 0, 0, 0, 2, 0));
        vecs.push_back(v(1, 1, 1, 0, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 1, 1));
        vecs.push_back(v(1, 0, 0, 0, 2, 0));
        vecs.push_back(v(1, 1, 0, 1, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 1));
        foreach (vecs[i]) begin
            cycle(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].rs);
            chk($sformatf("occupancy[%0d]", i), 192'(occupancy), 192'(vecs[i].occ));
            chk($sformatf("ready_tbl[%0d]", i), 192'(in_ready), 192'(vecs[i].rdy));
            started = 1;
        end
        cycle(1, 0, 0, 0);
        held = out_beat();
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("hold_stable", 192'(out_beat()), 192'(held));
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        chk("drain_occ", 192'(occupancy), 192'(0));
        chk("drain_q", 192'(mq.size()), 192'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
